// File: rtl/instruction_execute.sv
// RV32I execute stage: ALU, branch/jump resolution and the EX_MEM register bundle.
// Shifts use an iterative 1-bit engine unless EX_FAST_SHIFT_EN selects a barrel shifter.
module instruction_execute #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ID_EX_VALID,
  input  logic [XLEN-1:0] ID_EX_A,
  input  logic [XLEN-1:0] ID_EX_B,
  input  logic [XLEN-1:0] ID_EX_IMM,
  input  logic [XLEN-1:0] ID_EX_NPC,
  input  logic [XLEN-1:0] ID_EX_IR,
  input  logic [XLEN-1:0] ID_EX_PC,
  input  logic            MEM_STALL,
  output logic            EX_BUSY,
  output logic            BR_TAKEN,
  output logic [XLEN-1:0] PC_NEXT,
  output logic            EX_MEM_VALID,
  output logic [XLEN-1:0] EX_MEM_ALU,
  output logic [XLEN-1:0] EX_MEM_B,
  output logic [XLEN-1:0] EX_MEM_IR,
  output logic [XLEN-1:0] EX_MEM_NPC
);

  // state | meaning
  // IDLE  | accepting instructions, non-shift results registered in one cycle
  // SHIFT | iterative shift running, or finished and waiting for MEM_STALL to drop
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
  state_t state;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       alt;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic is_shift, go_shift, br_cond, taken, accept;
  logic [XLEN-1:0] op2, alu_op, alu_res, shift_res, sra_res, jalr_sum, tgt;
  logic [SHW-1:0]  shamt;

  logic [XLEN-1:0] sh_val, sh_ir, sh_npc, sh_b, sh_step, sh_nxt_val;
  logic [SHW-1:0]  sh_cnt, sh_nxt_cnt;
  logic            sh_left, sh_arith;

  assign opc      = ID_EX_IR[6:0];
  assign f3       = ID_EX_IR[14:12];
  assign alt      = ID_EX_IR[30];
  assign is_r     = (opc == 7'b0110011);
  assign is_i     = (opc == 7'b0010011);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);

  assign op2      = is_r ? ID_EX_B : ID_EX_IMM;
  assign shamt    = op2[SHW-1:0];
  assign is_shift = (is_r | is_i) & ((f3 == 3'b001) | (f3 == 3'b101));
  assign sra_res  = $signed(ID_EX_A) >>> shamt;

`ifdef EX_FAST_SHIFT_EN
  assign shift_res = (f3 == 3'b001) ? (ID_EX_A << shamt) :
                     (alt ? sra_res : (ID_EX_A >> shamt));
  assign go_shift  = 1'b0;
`else
  // Only shamt==0 completes here; any other amount goes through the SHIFT engine.
  assign shift_res = ID_EX_A;
  assign go_shift  = is_shift & (shamt != '0);
`endif

  always_comb begin
    alu_op = '0;
    case (f3)
      3'b000:  alu_op = (is_r & alt) ? (ID_EX_A - op2) : (ID_EX_A + op2);
      3'b010:  alu_op = {{(XLEN-1){1'b0}}, ($signed(ID_EX_A) < $signed(op2))};
      3'b011:  alu_op = {{(XLEN-1){1'b0}}, (ID_EX_A < op2)};
      3'b100:  alu_op = ID_EX_A ^ op2;
      3'b110:  alu_op = ID_EX_A | op2;
      3'b111:  alu_op = ID_EX_A & op2;
      default: alu_op = shift_res;
    endcase
  end

  always_comb begin
    alu_res = '0;
    if (is_r | is_i)          alu_res = alu_op;
    else if (is_ld | is_st)   alu_res = ID_EX_A + ID_EX_IMM;
    else if (is_jal | is_jalr) alu_res = ID_EX_NPC;
    else if (is_lui)          alu_res = ID_EX_IMM;
    else if (is_auipc)        alu_res = ID_EX_PC + ID_EX_IMM;
  end

  always_comb begin
    br_cond = 1'b0;
    case (f3)
      3'b000:  br_cond = (ID_EX_A == ID_EX_B);
      3'b001:  br_cond = (ID_EX_A != ID_EX_B);
      3'b100:  br_cond = ($signed(ID_EX_A) < $signed(ID_EX_B));
      3'b101:  br_cond = ($signed(ID_EX_A) >= $signed(ID_EX_B));
      3'b110:  br_cond = (ID_EX_A < ID_EX_B);
      3'b111:  br_cond = (ID_EX_A >= ID_EX_B);
      default: br_cond = 1'b0;
    endcase
  end

  assign taken    = (is_br & br_cond) | is_jal | is_jalr;
  assign jalr_sum = ID_EX_A + ID_EX_IMM;
  assign tgt      = (is_br | is_jal) ? (ID_EX_PC + ID_EX_IMM) :
                    (is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ID_EX_NPC);

  assign EX_BUSY = rst & ((state == SHIFT) | MEM_STALL);
  assign accept  = ID_EX_VALID & ~EX_BUSY & ~MEM_STALL;

  assign sh_step    = sh_left ? {sh_val[XLEN-2:0], 1'b0}
                              : {(sh_arith & sh_val[XLEN-1]), sh_val[XLEN-1:1]};
  assign sh_nxt_val = (sh_cnt != '0) ? sh_step : sh_val;
  assign sh_nxt_cnt = (sh_cnt != '0) ? (sh_cnt - 1'b1) : sh_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sh_val       <= '0;
      sh_cnt       <= '0;
      sh_left      <= 1'b0;
      sh_arith     <= 1'b0;
      sh_ir        <= '0;
      sh_npc       <= '0;
      sh_b         <= '0;
      EX_MEM_VALID <= 1'b0;
      EX_MEM_ALU   <= '0;
      EX_MEM_B     <= '0;
      EX_MEM_IR    <= '0;
      EX_MEM_NPC   <= '0;
      BR_TAKEN     <= 1'b0;
      PC_NEXT      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && go_shift) begin
            state        <= SHIFT;
            sh_val       <= ID_EX_A;
            sh_cnt       <= shamt;
            sh_left      <= (f3 == 3'b001);
            sh_arith     <= alt;
            sh_ir        <= ID_EX_IR;
            sh_npc       <= ID_EX_NPC;
            sh_b         <= ID_EX_B;
            EX_MEM_VALID <= 1'b0;
            BR_TAKEN     <= 1'b0;
          end else if (accept) begin
            EX_MEM_VALID <= 1'b1;
            EX_MEM_ALU   <= alu_res;
            EX_MEM_B     <= ID_EX_B;
            EX_MEM_IR    <= ID_EX_IR;
            EX_MEM_NPC   <= ID_EX_NPC;
            BR_TAKEN     <= taken;
            PC_NEXT      <= tgt;
          end else if (!MEM_STALL) begin
            EX_MEM_VALID <= 1'b0;
            BR_TAKEN     <= 1'b0;
          end
        end
        SHIFT: begin
          if ((sh_nxt_cnt == '0) && !MEM_STALL) begin
            state        <= IDLE;
            sh_cnt       <= '0;
            EX_MEM_VALID <= 1'b1;
            EX_MEM_ALU   <= sh_nxt_val;
            EX_MEM_B     <= sh_b;
            EX_MEM_IR    <= sh_ir;
            EX_MEM_NPC   <= sh_npc;
            BR_TAKEN     <= 1'b0;
            PC_NEXT      <= sh_npc;
          end else begin
            // Keep shifting under MEM_STALL; the finished value parks in sh_val.
            sh_val <= sh_nxt_val;
            sh_cnt <= sh_nxt_cnt;
            if (!MEM_STALL) begin
              EX_MEM_VALID <= 1'b0;
              BR_TAKEN     <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
